fir_capture_buffer: RTL and testbench



---
 rtl/capture_pkg.sv | 19 +
 rtl/capture_ram.sv | 27 ++
 rtl/fir_capture_buffer.sv | 129 ++++++++++++
 tb/tb_fir_capture_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared constants for the capture path: record geometry (common with the ROM
// interface) and the capture buffer state encoding.
package capture_pkg;

   localparam int unsigned CAP_DATA_W = 39;
   localparam int unsigned CAP_DEPTH  = 5500;
   localparam int unsigned CAP_ADDR_W = 13;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_READOUT = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      CAPTURE = ST_CAPTURE,
      READOUT = ST_READOUT
   } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port record store: one write port, one registered read port
// with read enable, single clock. Contents are never cleared.
module capture_ram #(
   parameter int unsigned DATA_W = 39,
   parameter int unsigned ADDR_W = 13
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // rd_data holds while rd_en is low; the top uses it as the first skid slot.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fir_capture_buffer.sv
// Captures one fixed-length record of FIR output samples into RAM, then
// replays it in order over a valid/ready stream.
module fir_capture_buffer
   import capture_pkg::*;
#(
   parameter int unsigned DATA_W = CAP_DATA_W,
   parameter int unsigned DEPTH  = CAP_DEPTH,
   parameter int unsigned ADDR_W = CAP_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm_i,
   input  logic [DATA_W-1:0] y_in,
   input  logic              valid_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              m_last_o,
   output logic [ADDR_W:0]   count_o,
   output logic              busy_o,
   output logic              overflow_o,
   output logic              done_o
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] REC_LEN  = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   rd_idx;
   logic              wr_en;
   logic              rd_en;
   logic              a_valid;
   logic              a_last;
   logic              a_take;
   logic              handshake;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_last;
   logic              overflow;
   logic              done;

   capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (count[ADDR_W-1:0]),
      .wr_data (y_in),
      .rd_en   (rd_en),
      .rd_addr (rd_idx[ADDR_W-1:0]),
      .rd_data (ram_q)
   );

   assign wr_en     = (state == CAPTURE) && valid_i;
   assign handshake = out_valid && m_ready_i;
   // Skid slot A (RAM read register) drains into the output register when
   // that register is empty or being accepted this cycle.
   assign a_take    = a_valid && (!out_valid || m_ready_i);
   assign rd_en     = (state == READOUT) && (rd_idx != REC_LEN) && (!a_valid || a_take);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         rd_idx    <= '0;
         a_valid   <= 1'b0;
         a_last    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (arm_i) begin
                  state    <= CAPTURE;
                  count    <= '0;
                  rd_idx   <= '0;
                  overflow <= 1'b0;
               end
            end
            CAPTURE: begin
               if (valid_i) begin
                  count <= count + 1'b1;
                  if (count == LAST_IDX) state <= READOUT;
               end
            end
            READOUT: begin
               if (valid_i) overflow <= 1'b1;
               if (handshake && out_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (rd_en) begin
            rd_idx  <= rd_idx + 1'b1;
            a_valid <= 1'b1;
            a_last  <= (rd_idx == LAST_IDX);
         end else if (a_take) begin
            a_valid <= 1'b0;
         end

         if (a_take) begin
            out_valid <= 1'b1;
            out_data  <= ram_q;
            out_last  <= a_last;
         end else if (handshake) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign m_data_o   = out_data;
   assign m_valid_o  = out_valid;
   assign m_last_o   = out_last;
   assign count_o    = count;
   assign busy_o     = (state != IDLE);
   assign overflow_o = overflow;
   assign done_o     = done;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Directed bench for fir_capture_buffer with an 8-sample record of 39-bit data.
module tb_fir_capture_buffer;

   localparam int DW = 39;
   localparam int DP = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          valid;
   logic          m_ready;
   logic [DW-1:0] y;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          busy;
   logic          overflow;
   logic          done;
   logic [AW:0]   count;

   int n_cmp = 0;
   int n_err = 0;
   logic [DW-1:0] exp_mem [DP];

   fir_capture_buffer #(
      .DATA_W (DW),
      .DEPTH  (DP),
      .ADDR_W (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .arm_i      (arm),
      .y_in       (y),
      .valid_i    (valid),
      .m_data_o   (m_data),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .m_last_o   (m_last),
      .count_o    (count),
      .busy_o     (busy),
      .overflow_o (overflow),
      .done_o     (done)
   );

   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mdata"},  m_data,   0);
      chk({tag, "_count"},  count,    0);
      chk({tag, "_mvalid"}, m_valid,  0);
      chk({tag, "_mlast"},  m_last,   0);
      chk({tag, "_busy"},   busy,     0);
      chk({tag, "_ovf"},    overflow, 0);
      chk({tag, "_done"},   done,     0);
   endtask

   task automatic do_arm(input logic with_valid);
      arm   = 1'b1;
      valid = with_valid;
      y     = '1;
      tick();
      arm   = 1'b0;
      valid = 1'b0;
      chk("arm_busy",  busy,     1);
      chk("arm_count", count,    0);
      chk("arm_ovf",   overflow, 0);
   endtask

   task automatic capture(input int gap, input int arm_at);
      for (int i = 0; i < DP; i++) begin
         if (i == arm_at) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
            chk("arm_in_capture", count, 64'(i));
         end
         if (i == DP - 1) begin
            chk("pre_last_count",  count,   DP - 1);
            chk("pre_last_busy",   busy,    1);
            chk("pre_last_mvalid", m_valid, 0);
         end
         valid = 1'b1;
         y     = exp_mem[i];
         tick();
         valid = 1'b0;
         chk("wr_count", count, 64'(i + 1));
         if (i < DP - 1) repeat (gap) tick();
      end
   endtask

   task automatic drain(input int mode, input int n_take, input int want_lat);
      int            got = 0;
      int            cyc = 0;
      int            first = -1;
      logic          stalled = 1'b0;
      logic [DW-1:0] held = '0;
      while (got < n_take && cyc < 400) begin
         m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (stalled) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data",  m_data,  held);
         end
         if (mode == 0 && first >= 0) chk("no_bubble", m_valid, 1);
         if (m_valid && first < 0) first = cyc;
         if (m_valid && m_ready) begin
            chk("rd_data", m_data, exp_mem[got]);
            chk("rd_last", m_last, 64'(got == DP - 1));
            got++;
            stalled = 1'b0;
         end else begin
            stalled = m_valid;
            held    = m_data;
         end
         tick();
         cyc++;
      end
      chk("drain_count", got, n_take);
      if (want_lat >= 0) chk("first_latency", first, want_lat);
      if (n_take == DP) begin
         chk("done_pulse",  done,    1);
         chk("done_busy",   busy,    0);
         chk("done_mvalid", m_valid, 0);
         chk("done_count",  count,   DP);
         m_ready = 1'b0;
         tick();
         chk("done_single", done, 0);
      end
   endtask

   initial begin
      rst     = 1'b1;
      arm     = 1'b0;
      valid   = 1'b0;
      y       = '0;
      m_ready = 1'b0;
      repeat (3) tick();
      chk_reset_vals("rst");
      rst = 1'b0;
      tick();

      // valid_i in IDLE is ignored
      valid = 1'b1;
      y     = 39'd5;
      repeat (3) tick();
      valid = 1'b0;
      chk("idle_count", count,    0);
      chk("idle_ovf",   overflow, 0);
      chk("idle_busy",  busy,     0);

      // basic: -4..3, back-to-back, valid coincident with arm dropped
      for (int i = 0; i < DP; i++) exp_mem[i] = DW'(i - 4);
      do_arm(1'b1);
      capture(0, -1);
      drain(0, DP, 2);

      // gapped extremes
      for (int i = 0; i < DP; i++) begin
         case (i % 4)
            0:       exp_mem[i] = 39'h7F_FFFF_FFFF;
            1:       exp_mem[i] = 39'h40_0000_0000;
            2:       exp_mem[i] = 39'h3F_FFFF_FFFF;
            default: exp_mem[i] = 39'h00_0000_0001;
         endcase
      end
      do_arm(1'b0);
      capture(2, -1);
      drain(0, DP, 2);

      // random backpressure
      for (int i = 0; i < DP; i++) exp_mem[i] = DW'(64'h15_5555_0000 + 64'(i) * 64'h1_0001);
      do_arm(1'b0);
      capture(0, -1);
      drain(1, DP, -1);

      // overflow: 12 valid cycles with readout stalled
      for (int i = 0; i < DP; i++) exp_mem[i] = DW'(1000 + i * 7);
      do_arm(1'b0);
      m_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         valid = 1'b1;
         y     = DW'(1000 + i * 7);
         tick();
         if (i == DP - 1) chk("ovf_at_8", overflow, 0);
         if (i == DP)     chk("ovf_after_8", overflow, 1);
      end
      valid = 1'b0;
      chk("ovf_count", count, DP);
      drain(0, DP, -1);
      chk("ovf_hold", overflow, 1);
      do_arm(1'b0);

      // reset after 3 handshakes, then full recapture
      for (int i = 0; i < DP; i++) exp_mem[i] = DW'(50 + i * 3);
      capture(0, -1);
      drain(0, 3, 2);
      rst = 1'b1;
      tick();
      chk_reset_vals("midrst");
      rst = 1'b0;
      tick();
      for (int i = 0; i < DP; i++) exp_mem[i] = ~DW'(i * 11);
      do_arm(1'b0);
      capture(0, -1);
      drain(0, DP, 2);

      // arm during CAPTURE is ignored
      for (int i = 0; i < DP; i++) exp_mem[i] = DW'(64'h2A_0000_0000 - 64'(i));
      do_arm(1'b0);
      capture(0, 3);
      drain(0, DP, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
